// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and constants for the SAR ADC sequencer.
// Holds the FSM state enum, phase-select encoding, default phase
// lengths and a helper computing start-to-result latency T.
package adc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SAMP,
      COMP,
      UPDATE,
      GAP,
      DONE
   } state_e;

   // Which seq_* line is active; one-of-N so outputs can never overlap.
   typedef enum logic [2:0] {
      PH_NONE,
      PH_INIT,
      PH_SAMP,
      PH_COMP,
      PH_UPDATE
   } phase_e;

   localparam int unsigned DEF_N_BITS     = 16;
   localparam int unsigned DEF_INIT_LEN   = 2;
   localparam int unsigned DEF_SAMP_LEN   = 4;
   localparam int unsigned DEF_COMP_LEN   = 1;
   localparam int unsigned DEF_UPDATE_LEN = 1;
   localparam int unsigned DEF_NOVL       = 1;
   localparam int unsigned DEF_LEN_W      = 8;

   // Clock edges from the start edge to the edge that enters DONE.
   function automatic int unsigned conv_cycles(
      input int unsigned n_bits,
      input int unsigned init_len,
      input int unsigned samp_len,
      input int unsigned comp_len,
      input int unsigned update_len,
      input int unsigned novl
   );
      return init_len + samp_len
           + n_bits * (comp_len + update_len)
           + (2 * n_bits + 2) * novl;
   endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: loadable LEN_W-bit down counter shared by all phases.
// Ports: clk, rst (async high), load, len in; last high on final cycle.
module adc_seq_timer
   import adc_seq_pkg::*;
#(
   parameter int unsigned LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   output logic             last
);

   logic [LEN_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= len;
      end else if (cnt_q > LEN_W'(1)) begin
         cnt_q <= cnt_q - LEN_W'(1);
      end
   end

   assign last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/adc_seqgen.sv
// adc_seqgen: SAR ADC timing sequencer. On start it runs INIT, SAMP and
// N_BITS x (COMP, UPDATE) phases with non-overlap gaps, shifts comp_out
// in MSB-first and returns the word via result_valid/result_ready.
// Ports: clk, rst (async high), start, busy, seq_init/samp/comp/update,
// comp_out, result, result_valid, result_ready, cont (ADC_SEQ_CONT_EN).
module adc_seqgen
   import adc_seq_pkg::*;
#(
   parameter int unsigned N_BITS     = DEF_N_BITS,
   parameter int unsigned INIT_LEN   = DEF_INIT_LEN,
   parameter int unsigned SAMP_LEN   = DEF_SAMP_LEN,
   parameter int unsigned COMP_LEN   = DEF_COMP_LEN,
   parameter int unsigned UPDATE_LEN = DEF_UPDATE_LEN,
   parameter int unsigned NOVL       = DEF_NOVL,
   parameter int unsigned LEN_W      = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              seq_init,
   output logic              seq_samp,
   output logic              seq_comp,
   output logic              seq_update,
   input  logic              comp_out,
   output logic [N_BITS-1:0] result,
   output logic              result_valid,
`ifdef ADC_SEQ_CONT_EN
   input  logic              cont,
`endif
   input  logic              result_ready
);

   localparam int unsigned BC_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   state_e            state_q, state_n;
   state_e            ret_q, ret_n;
   state_e            follow;
   phase_e            ph_n;
   logic              load;
   logic [LEN_W-1:0]  len;
   logic              last;
   logic              last_bit;
   logic              cont_i;
   logic [BC_W-1:0]   bit_q;
   logic [N_BITS-1:0] shift_q;

`ifdef ADC_SEQ_CONT_EN
   assign cont_i = cont;
`else
   assign cont_i = 1'b0;
`endif

   function automatic logic [LEN_W-1:0] len_of(input state_e s);
      case (s)
         INIT:    return LEN_W'(INIT_LEN);
         SAMP:    return LEN_W'(SAMP_LEN);
         COMP:    return LEN_W'(COMP_LEN);
         UPDATE:  return LEN_W'(UPDATE_LEN);
         default: return '0;
      endcase
   endfunction

   adc_seq_timer #(
      .LEN_W (LEN_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .len  (len),
      .last (last)
   );

   assign last_bit = (bit_q == BC_W'(N_BITS - 1));

   // Phase that follows the current active phase (ignoring gaps).
   always_comb begin
      follow = IDLE;
      case (state_q)
         INIT:    follow = SAMP;
         SAMP:    follow = COMP;
         COMP:    follow = UPDATE;
         UPDATE:  follow = last_bit ? DONE : COMP;
         default: follow = IDLE;
      endcase
   end

   always_comb begin
      state_n = state_q;
      ret_n   = ret_q;
      load    = 1'b0;
      len     = '0;
      ph_n    = PH_NONE;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = INIT;
               load    = 1'b1;
               len     = LEN_W'(INIT_LEN);
            end
         end
         INIT, SAMP, COMP, UPDATE: begin
            if (last) begin
               load = 1'b1;
               if (NOVL != 0) begin
                  state_n = GAP;
                  ret_n   = follow;
                  len     = LEN_W'(NOVL);
               end else begin
                  state_n = follow;
                  len     = len_of(follow);
               end
            end
         end
         GAP: begin
            if (last) begin
               state_n = ret_q;
               load    = 1'b1;
               len     = len_of(ret_q);
            end
         end
         DONE: begin
            if (result_ready) begin
               if (cont_i) begin
                  state_n = INIT;
                  load    = 1'b1;
                  len     = LEN_W'(INIT_LEN);
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // seq_* are registered from the next state so they are glitch-free.
      case (state_n)
         INIT:    ph_n = PH_INIT;
         SAMP:    ph_n = PH_SAMP;
         COMP:    ph_n = PH_COMP;
         UPDATE:  ph_n = PH_UPDATE;
         default: ph_n = PH_NONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ret_q        <= IDLE;
         bit_q        <= '0;
         shift_q      <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         seq_init     <= 1'b0;
         seq_samp     <= 1'b0;
         seq_comp     <= 1'b0;
         seq_update   <= 1'b0;
      end else begin
         state_q <= state_n;
         ret_q   <= ret_n;
         if (load && state_n == INIT) begin
            bit_q   <= '0;
            shift_q <= '0;
         end
         // Decision taken on the last edge of COMP, seq_comp still high.
         if (state_q == COMP && last) begin
            shift_q <= (shift_q << 1) | N_BITS'(comp_out);
         end
         if (state_q == UPDATE && last) begin
            bit_q <= bit_q + BC_W'(1);
         end
         if (state_n == DONE && state_q != DONE) begin
            result <= shift_q;
         end
         result_valid <= (state_n == DONE);
         busy         <= (state_n != IDLE) && (state_n != DONE);
         seq_init     <= (ph_n == PH_INIT);
         seq_samp     <= (ph_n == PH_SAMP);
         seq_comp     <= (ph_n == PH_COMP);
         seq_update   <= (ph_n == PH_UPDATE);
      end
   end

endmodule
